// File: rtl/grid_pkg.sv
// Shared encodings for the grid claim arbiter: op codes, empty-cell marker, FSM states.
// Constants only, no logic, so there is no latency and no backpressure.
package grid_pkg;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_CLAIM   = 2'd1;
  localparam logic [1:0] OP_RELEASE = 2'd2;

  // Wide enough for any DATA_W up to 64; users slice the low bits.
  localparam logic [63:0] EMPTY_CELL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD,
    ST_WAIT,
    ST_DECIDE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; the grant is combinational and the pointer moves to winner+1 on accept.
// Zero latency; requests not accepted keep their place and the pointer holds.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  input  logic             accept_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        grant_o[idx]   = 1'b1;
        grant_idx_o    = IDX_W'(idx);
      end
    end
  end

  assign any_o = found;
  assign ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : IDX_W'(int'(grant_idx_o) + 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (accept_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/grid_claim_arbiter.sv
// Serialises atomic READ/CLAIM/RELEASE on a single-port grid RAM among NREQ engines, round-robin.
// Accept-to-response is 5 cycles in bounds, 2 out of bounds; one transaction in flight, others wait on req_ready.
module grid_claim_arbiter
  import grid_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int GRID_N  = 6,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int COORD_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [COORD_W*NREQ-1:0]   req_x,
  input  logic [COORD_W*NREQ-1:0]   req_y,
  input  logic [DATA_W*NREQ-1:0]    req_node,
  output logic [NREQ-1:0]           rsp_valid,
  output logic                      rsp_ok,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout,
  output logic [CNT_W-1:0]          claim_ok_cnt,
  output logic [CNT_W-1:0]          claim_fail_cnt
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [DATA_W-1:0]         EMPTY  = EMPTY_CELL[DATA_W-1:0];
  localparam logic signed [COORD_W-1:0] GRID_S = COORD_W'(GRID_N);

  state_e state_q, state_d;

  logic [1:0]                 op_q;
  logic signed [COORD_W-1:0]  x_q, y_q;
  logic [DATA_W-1:0]          node_q;
  logic [NREQ-1:0]            gnt_q;
  logic                       ok_q;
  logic [DATA_W-1:0]          data_q;
  logic [CNT_W-1:0]           ok_cnt_q, fail_cnt_q;

  logic [NREQ-1:0]            grant;
  logic [IDX_W-1:0]           gidx;
  logic                       any_req;
  logic                       accept;
  logic                       in_bounds;
  logic                       mem_access;
  logic [ADDR_W-1:0]          lin_addr;
  logic                       decide_ok;

  assign accept = (state_q == ST_IDLE) && !reset;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .any_o       (any_req)
  );

  assign in_bounds  = !x_q[COORD_W-1] && (x_q < GRID_S) && !y_q[COORD_W-1] && (y_q < GRID_S);
  assign mem_access = in_bounds && (op_q != 2'd3);
  // Truncating operands first gives the same low bits as truncating the full product.
  assign lin_addr   = ADDR_W'(x_q) * ADDR_W'(GRID_N) + ADDR_W'(y_q);

  always_comb begin
    decide_ok = 1'b0;
    case (op_q)
      OP_READ:    decide_ok = 1'b1;
      OP_CLAIM:   decide_ok = (mem_dout == EMPTY);
      OP_RELEASE: decide_ok = (mem_dout == node_q);
      default:    decide_ok = 1'b0;
    endcase
  end

  // Strobes are gated by reset so an abort in DECIDE never writes.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    rsp_valid = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            req_ready = grant;
            state_d   = ST_CHECK;
          end
        end
        ST_CHECK:  state_d = mem_access ? ST_RD : ST_RESP;
        ST_RD: begin
          mem_read = 1'b1;
          mem_addr = lin_addr;
          state_d  = ST_WAIT;
        end
        ST_WAIT:   state_d = ST_DECIDE;
        ST_DECIDE: begin
          if (decide_ok && (op_q != OP_READ)) begin
            mem_write = 1'b1;
            mem_addr  = lin_addr;
            mem_din   = (op_q == OP_CLAIM) ? node_q : EMPTY;
          end
          state_d = ST_RESP;
        end
        ST_RESP: begin
          rsp_valid = gnt_q;
          state_d   = ST_IDLE;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      node_q     <= '0;
      gnt_q      <= '0;
      ok_q       <= 1'b0;
      data_q     <= '0;
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            op_q   <= req_op[int'(gidx)*2 +: 2];
            x_q    <= req_x[int'(gidx)*COORD_W +: COORD_W];
            y_q    <= req_y[int'(gidx)*COORD_W +: COORD_W];
            node_q <= req_node[int'(gidx)*DATA_W +: DATA_W];
            gnt_q  <= grant;
          end
        end
        ST_CHECK: begin
          if (!mem_access) begin
            ok_q   <= 1'b0;
            data_q <= EMPTY;
            if (op_q == OP_CLAIM && ~&fail_cnt_q) fail_cnt_q <= fail_cnt_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          data_q <= mem_dout;
          ok_q   <= decide_ok;
          if (op_q == OP_CLAIM) begin
            if (decide_ok) begin
              if (~&ok_cnt_q) ok_cnt_q <= ok_cnt_q + 1'b1;
            end else if (~&fail_cnt_q) begin
              fail_cnt_q <= fail_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_ok         = ok_q;
  assign rsp_data       = data_q;
  assign claim_ok_cnt   = ok_cnt_q;
  assign claim_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_grid_claim_arbiter.sv
// Directed plus random traffic against a transaction-level grid model with a RAM behind the DUT.
// Expected grants, strobes, responses and counters come from the model's rules and latencies.
module tb_grid_claim_arbiter;

  localparam int NREQ = 4;
  localparam int GN   = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [7:0]         req_op;
  logic [127:0]       req_x, req_y, req_node;
  logic [3:0]         rsp_valid;
  logic               rsp_ok;
  logic [31:0]        rsp_data;
  logic               mem_read, mem_write;
  logic [11:0]        mem_addr;
  logic [31:0]        mem_din;
  logic [31:0]        mem_dout;
  logic [15:0]        claim_ok_cnt, claim_fail_cnt;

  always #5 clk = ~clk;

  grid_claim_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_node(req_node),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_data(rsp_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .claim_ok_cnt(claim_ok_cnt), .claim_fail_cnt(claim_fail_cnt)
  );

  // Grid RAM: registered read port, holds dout between reads.
  logic [31:0] ram [4096];
  logic        init_ram;
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '1;
    end else begin
      if (mem_read)  mem_dout <= ram[mem_addr];
      if (mem_write) ram[mem_addr] <= mem_din;
    end
  end

  int tests = 0;
  int fails = 0;

  // Pending requests per requester.
  bit          pv [4];
  logic [1:0]  pop[4];
  int          px [4];
  int          py [4];
  logic [31:0] pn [4];

  // Reference model state.
  logic [31:0] refg [GN*GN];
  int          rr_ptr, cyc, ta, lat, cur_owner, cur_addr;
  bit          busy, cur_rd, cur_wr, cur_ok;
  logic [31:0] cur_data, cur_din;
  int          okc, failc;
  logic [3:0]  grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input int x, input int y, input logic [31:0] n);
    pv[r] = 1'b1; pop[r] = op; px[r] = x; py[r] = y; pn[r] = n;
  endtask

  task automatic start_txn(input int g);
    bit inb;
    inb = px[g] >= 0 && px[g] < GN && py[g] >= 0 && py[g] < GN;
    cur_owner = g; ta = cyc; busy = 1'b1; cur_rd = 1'b0; cur_wr = 1'b0;
    if (!inb || pop[g] == 2'd3) begin
      lat = 2; cur_ok = 1'b0; cur_data = '1;
      if (pop[g] == 2'd1) failc++;
    end else begin
      lat = 5; cur_rd = 1'b1;
      cur_addr = px[g] * GN + py[g];
      cur_data = refg[cur_addr];
      case (pop[g])
        2'd0: cur_ok = 1'b1;
        2'd1: begin
          cur_ok = (cur_data == 32'hFFFF_FFFF);
          if (cur_ok) begin cur_wr = 1'b1; cur_din = pn[g]; okc++; end
          else failc++;
        end
        default: begin
          cur_ok = (cur_data == pn[g]);
          if (cur_ok) begin cur_wr = 1'b1; cur_din = '1; end
        end
      endcase
    end
  endtask

  task automatic drive();
    for (int r = 0; r < 4; r++) begin
      req_valid[r]          = pv[r];
      req_op[r*2 +: 2]      = pop[r];
      req_x[r*32 +: 32]     = 32'(px[r]);
      req_y[r*32 +: 32]     = 32'(py[r]);
      req_node[r*32 +: 32]  = pn[r];
    end
  endtask

  // One clock: drive, sample mid-cycle against the model, advance.
  task automatic tick();
    logic [3:0] exp_rdy, exp_rsp;
    bit acc;
    int g;
    drive();
    #1;
    exp_rdy = '0; acc = 1'b0; g = 0;
    if (!busy) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        r = (rr_ptr + i) % 4;
        if (!acc && pv[r]) begin acc = 1'b1; g = r; end
      end
    end
    if (acc) begin
      exp_rdy[g] = 1'b1;
      start_txn(g);
      rr_ptr = (g + 1) % 4;
    end
    chk("req_ready", req_ready, exp_rdy);
    if (acc) grant_log.push_back(req_ready);
    chk("mem_read", mem_read, busy && cur_rd && cyc == ta + 2);
    chk("mem_write", mem_write, busy && cur_wr && cyc == ta + 4);
    if (busy && cur_rd && cyc == ta + 2) chk("rd_addr", mem_addr, cur_addr);
    if (busy && cur_wr && cyc == ta + 4) begin
      chk("wr_addr", mem_addr, cur_addr);
      chk("wr_din", mem_din, cur_din);
      refg[cur_addr] = cur_din;
    end
    exp_rsp = '0;
    if (busy && cyc == ta + lat) exp_rsp[cur_owner] = 1'b1;
    chk("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp != 0) begin
      chk("rsp_ok", rsp_ok, cur_ok);
      chk("rsp_data", rsp_data, cur_data);
      chk("claim_ok_cnt", claim_ok_cnt, okc);
      chk("claim_fail_cnt", claim_fail_cnt, failc);
      busy = 1'b0;
    end
    if (acc) pv[g] = 1'b0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || pv[0] || pv[1] || pv[2] || pv[3]) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_budget", n < 300, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; init_ram = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, 2'd0, 0, 0, 0);
    for (int r = 0; r < 4; r++) pv[r] = 1'b0;
    drive();
    for (int i = 0; i < GN*GN; i++) refg[i] = '1;
    rr_ptr = 0; cyc = 0; busy = 1'b0; okc = 0; failc = 0;
    cur_rd = 1'b0; cur_wr = 1'b0; ta = 0; lat = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; init_ram = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_ok", rsp_ok, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_ok_cnt", claim_ok_cnt, 0);
    chk("rst_fail_cnt", claim_fail_cnt, 0);

    // Single claim of (2,3) by requester 0.
    set_req(0, 2'd1, 2, 3, 7); drain();
    // Bring the pointer back to requester 0.
    set_req(3, 2'd0, 0, 0, 0); drain();
    // Collision on (1,1).
    set_req(0, 2'd1, 1, 1, 4); set_req(1, 2'd1, 1, 1, 5); drain();
    // Out of bounds both ways.
    set_req(2, 2'd1, 6, 0, 8); drain();
    set_req(2, 2'd1, -1, 2, 8); drain();
    set_req(1, 2'd3, 0, 0, 8); drain();
    // Release by wrong and right owner, then read back.
    set_req(1, 2'd2, 2, 3, 9); drain();
    set_req(1, 2'd2, 2, 3, 7); drain();
    set_req(1, 2'd0, 2, 3, 0); drain();

    // Abort a claim in DECIDE.
    begin
      int n;
      n = 0;
      set_req(2, 2'd1, 4, 4, 3);
      while (!(busy && cyc == ta + 4) && n < 20) begin tick(); n++; end
      chk("reach_decide", n < 20, 1);
      reset = 1'b1;
      drive();
      #1;
      chk("abort_mem_write", mem_write, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      cyc++;
      reset = 1'b0;
      busy = 1'b0; rr_ptr = 0; okc = 0; failc = 0;
      #1;
      chk("abort_ok_cnt", claim_ok_cnt, 0);
      chk("abort_fail_cnt", claim_fail_cnt, 0);
      chk("abort_req_ready", req_ready, 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("abort_no_rsp", rsp_valid, 0);
      end
    end

    // Fairness from pointer 0; requester 0 reads the aborted cell.
    grant_log.delete();
    set_req(0, 2'd0, 4, 4, 0);
    set_req(1, 2'd0, 1, 1, 0);
    set_req(2, 2'd0, 2, 3, 0);
    set_req(3, 2'd0, 5, 5, 0);
    begin
      int n;
      n = 0;
      while (grant_log.size() < 8 && n < 200) begin
        for (int r = 0; r < 4; r++) if (!pv[r]) set_req(r, 2'd0, r, r + 1, 0);
        tick();
        n++;
      end
      chk("fair_budget", n < 200, 1);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] e;
      e = 4'b0001 << (i % 4);
      chk("fair_order", (i < grant_log.size()) ? grant_log[i] : 4'b0, e);
    end

    // Random mixed traffic with drops.
    for (int k = 0; k < 1500; k++) begin
      for (int r = 0; r < 4; r++) begin
        if (!pv[r]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(r, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)) - 1,
                    int'($urandom_range(0, 7)) - 1, 32'($urandom_range(0, 5)));
        end else if ($urandom_range(0, 19) == 0) begin
          pv[r] = 1'b0;
        end
      end
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
